// File: rtl/wb_regfile_write_arbiter_if.sv
// Bus bundle between the WB stage / debug unit and the register-file write arbiter.
// The master side presents write requests; the slave side owns the register-file write port.
interface wb_regfile_write_arbiter_if #(
    parameter int REGS       = 5,
    parameter int NB_DATA    = 32,
    parameter int FIFO_DEPTH = 2
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic               i_wb_valid;
    logic [REGS-1:0]    i_wb_RD;
    logic               i_wb_JAL;
    logic [NB_DATA-1:0] i_wb_data;
    logic               i_dbg_valid;
    logic [REGS-1:0]    i_dbg_RD;
    logic [NB_DATA-1:0] i_dbg_data;
    logic               o_dbg_ready;
    logic               o_stall_wb;
    logic               o_rf_we;
    logic [REGS-1:0]    o_rf_addr;
    logic [NB_DATA-1:0] o_rf_data;
    logic [CW-1:0]      o_dbg_count;

    modport master (
        output i_wb_valid, i_wb_RD, i_wb_JAL, i_wb_data,
        output i_dbg_valid, i_dbg_RD, i_dbg_data,
        input  o_dbg_ready, o_stall_wb, o_rf_we, o_rf_addr, o_rf_data, o_dbg_count
    );

    modport slave (
        input  i_wb_valid, i_wb_RD, i_wb_JAL, i_wb_data,
        input  i_dbg_valid, i_dbg_RD, i_dbg_data,
        output o_dbg_ready, o_stall_wb, o_rf_we, o_rf_addr, o_rf_data, o_dbg_count
    );
endinterface

// File: rtl/wb_regfile_write_arbiter.sv
// Single register-file write port shared by the WB stream and buffered debug writes.
// WB has priority; a starved debug head forces a one-cycle WB freeze to drain.
module wb_regfile_write_arbiter #(
    parameter int REGS       = 5,
    parameter int NB_DATA    = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                     i_clk,
    input logic                     i_rst_n,
    wb_regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [REGS-1:0]    mem_rd_r   [FIFO_DEPTH];
    logic [NB_DATA-1:0] mem_data_r [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [SW-1:0]      starve_r;
    logic               stall_r;
    logic               ready_r;
    logic               rf_we_r;
    logic [REGS-1:0]    rf_addr_r;
    logic [NB_DATA-1:0] rf_data_r;

    logic [REGS-1:0]    eff_rd_s;
    logic               empty_s;
    logic               wb_req_s;
    logic               grant_dbg_s;
    logic               push_s;
    logic [REGS-1:0]    head_rd_s;
    logic [NB_DATA-1:0] head_data_s;
    logic [CW-1:0]      count_nxt_s;
    logic [SW-1:0]      starve_nxt_s;

    // Request decode, grant selection and next-state for occupancy and starvation.
    always_comb begin
        eff_rd_s     = bus.i_wb_JAL ? {REGS{1'b1}} : bus.i_wb_RD;
        empty_s      = (count_r == {CW{1'b0}});
        wb_req_s     = bus.i_wb_valid & ~stall_r & (eff_rd_s != {REGS{1'b0}});
        grant_dbg_s  = ~empty_s & (stall_r | ~wb_req_s);
        push_s       = bus.i_dbg_valid & ready_r;
        head_rd_s    = mem_rd_r[rd_ptr_r];
        head_data_s  = mem_data_r[rd_ptr_r];
        count_nxt_s  = count_r;
        starve_nxt_s = starve_r;
        case ({push_s, grant_dbg_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
        if (grant_dbg_s || empty_s) begin
            starve_nxt_s = {SW{1'b0}};
        end else if (starve_r != STARVE_TOP) begin
            starve_nxt_s = starve_r + SW'(1'b1);
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Debug FIFO storage and wrapping pointers; a fresh entry is only visible next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_rd_r[i]   <= {REGS{1'b0}};
                mem_data_r[i] <= {NB_DATA{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_rd_r[wr_ptr_r]   <= bus.i_dbg_RD;
                mem_data_r[wr_ptr_r] <= bus.i_dbg_data;
                wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
            end
            if (grant_dbg_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
        end
    end

    // Registered write port, occupancy, starvation counter and the flags decoded from them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rf_we_r   <= 1'b0;
            rf_addr_r <= {REGS{1'b0}};
            rf_data_r <= {NB_DATA{1'b0}};
            count_r   <= {CW{1'b0}};
            starve_r  <= {SW{1'b0}};
            stall_r   <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            if (wb_req_s) begin
                rf_we_r   <= 1'b1;
                rf_addr_r <= eff_rd_s;
                rf_data_r <= bus.i_wb_data;
            end else if (grant_dbg_s) begin
                // r0 debug writes still drain from the FIFO but never reach the file.
                rf_we_r   <= (head_rd_s != {REGS{1'b0}});
                rf_addr_r <= head_rd_s;
                rf_data_r <= head_data_s;
            end else begin
                rf_we_r   <= 1'b0;
            end
            count_r  <= count_nxt_s;
            starve_r <= starve_nxt_s;
            stall_r  <= (starve_nxt_s == STARVE_TOP);
            ready_r  <= (count_nxt_s != DEPTH_C);
        end
    end

    assign bus.o_rf_we     = rf_we_r;
    assign bus.o_rf_addr   = rf_addr_r;
    assign bus.o_rf_data   = rf_data_r;
    assign bus.o_dbg_count = count_r;
    assign bus.o_stall_wb  = stall_r;
    assign bus.o_dbg_ready = ready_r;
endmodule

// File: tb/tb_wb_regfile_write_arbiter.sv
// Directed bench for wb_regfile_write_arbiter: queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_wb_regfile_write_arbiter;
    localparam int REGS       = 5;
    localparam int NB_DATA    = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic rst_n;
    logic check_en;
    int   n_chk;
    int   n_bad;

    wb_regfile_write_arbiter_if #(.REGS(REGS), .NB_DATA(NB_DATA), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    wb_regfile_write_arbiter #(
        .REGS(REGS), .NB_DATA(NB_DATA), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: debug queue, starvation count, expected registered write.
    int          q_rd[$];
    logic [31:0] q_data[$];
    int          m_starve;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_data;
    bit          m_stall;
    bit          m_wbreq;
    bit          m_gdbg;
    bit          m_nonempty;
    int          m_eff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_rd.delete();
            q_data.delete();
            m_starve = 0;
            m_we     = 1'b0;
            m_addr   = 0;
            m_data   = 32'h0;
        end else begin
            m_stall    = (m_starve == STARVE_MAX);
            m_eff      = bus.i_wb_JAL ? 31 : int'(bus.i_wb_RD);
            m_wbreq    = bus.i_wb_valid && !m_stall && (m_eff != 0);
            m_nonempty = (q_rd.size() > 0);
            m_gdbg     = m_nonempty && (m_stall || !m_wbreq);
            m_we       = 1'b0;
            if (m_wbreq) begin
                m_we   = 1'b1;
                m_addr = m_eff;
                m_data = bus.i_wb_data;
            end else if (m_gdbg) begin
                m_we   = (q_rd[0] != 0);
                m_addr = q_rd[0];
                m_data = q_data[0];
            end
            if (m_gdbg || !m_nonempty) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
            if (m_gdbg) begin
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end
            if (bus.i_dbg_valid && (q_rd.size() + (m_gdbg ? 1 : 0) != FIFO_DEPTH)) begin
                q_rd.push_back(int'(bus.i_dbg_RD));
                q_data.push_back(bus.i_dbg_data);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("m_we",    32'(bus.o_rf_we),     32'(m_we));
            chk("m_count", 32'(bus.o_dbg_count), 32'(q_rd.size()));
            chk("m_ready", 32'(bus.o_dbg_ready), 32'(q_rd.size() != FIFO_DEPTH));
            chk("m_stall", 32'(bus.o_stall_wb),  32'(m_starve == STARVE_MAX));
            if (m_we) begin
                chk("m_addr", 32'(bus.o_rf_addr), 32'(m_addr));
                chk("m_data", bus.o_rf_data,      m_data);
            end
        end
    end

    task automatic drive_wb(input logic v, input logic [4:0] rd, input logic jal, input logic [31:0] d);
        bus.i_wb_valid = v;
        bus.i_wb_RD    = rd;
        bus.i_wb_JAL   = jal;
        bus.i_wb_data  = d;
    endtask

    task automatic drive_dbg(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.i_dbg_valid = v;
        bus.i_dbg_RD    = rd;
        bus.i_dbg_data  = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        check_en = 1'b0;
        rst_n    = 1'b0;
        drive_wb(1'b0, 5'd0, 1'b0, 32'h0);
        drive_dbg(1'b0, 5'd0, 32'h0);
        repeat (3) step();
        rst_n    = 1'b1;
        check_en = 1'b1;
        chk("rst_we",    32'(bus.o_rf_we),     32'd0);
        chk("rst_ready", 32'(bus.o_dbg_ready), 32'd1);
        chk("rst_stall", 32'(bus.o_stall_wb),  32'd0);
        chk("rst_count", 32'(bus.o_dbg_count), 32'd0);

        // JAL forces r31; a plain r0 write is dropped and the port holds its address.
        drive_wb(1'b1, 5'd7, 1'b1, 32'h00400008);
        step();
        chk("jal_we",   32'(bus.o_rf_we),   32'd1);
        chk("jal_addr", 32'(bus.o_rf_addr), 32'd31);
        chk("jal_data", bus.o_rf_data,      32'h00400008);
        drive_wb(1'b1, 5'd0, 1'b0, 32'hDEADBEEF);
        step();
        chk("r0_we",   32'(bus.o_rf_we),   32'd0);
        chk("r0_hold", 32'(bus.o_rf_addr), 32'd31);
        drive_wb(1'b0, 5'd0, 1'b0, 32'h0);

        // Two debug writes with WB idle drain in order.
        drive_dbg(1'b1, 5'd3, 32'hAA);
        step();
        chk("dbg1_count", 32'(bus.o_dbg_count), 32'd1);
        chk("dbg1_we",    32'(bus.o_rf_we),     32'd0);
        drive_dbg(1'b1, 5'd4, 32'hBB);
        step();
        chk("dbg1_addr", 32'(bus.o_rf_addr), 32'd3);
        chk("dbg1_data", bus.o_rf_data,      32'hAA);
        drive_dbg(1'b0, 5'd0, 32'h0);
        step();
        chk("dbg2_addr",  32'(bus.o_rf_addr),   32'd4);
        chk("dbg2_data",  bus.o_rf_data,        32'hBB);
        chk("dbg2_ready", 32'(bus.o_dbg_ready), 32'd1);
        step();

        // Starvation: WB writes r9 every cycle while one debug write waits.
        drive_wb(1'b1, 5'd9, 1'b0, 32'h99);
        drive_dbg(1'b1, 5'd5, 32'h55);
        step();
        chk("stv_wb_addr", 32'(bus.o_rf_addr), 32'd9);
        drive_dbg(1'b0, 5'd0, 32'h0);
        repeat (3) step();
        chk("stv_pre", 32'(bus.o_stall_wb), 32'd0);
        step();
        chk("stv_stall", 32'(bus.o_stall_wb), 32'd1);
        step();
        chk("stv_dbg_addr", 32'(bus.o_rf_addr),  32'd5);
        chk("stv_dbg_data", bus.o_rf_data,       32'h55);
        chk("stv_clear",    32'(bus.o_stall_wb), 32'd0);
        step();
        chk("stv_wb_back", 32'(bus.o_rf_addr), 32'd9);

        // A non-JAL WB write to r0 yields the slot to the pending debug head.
        drive_dbg(1'b1, 5'd8, 32'h88);
        step();
        drive_dbg(1'b0, 5'd0, 32'h0);
        drive_wb(1'b1, 5'd0, 1'b0, 32'h1234);
        step();
        chk("yield_addr", 32'(bus.o_rf_addr), 32'd8);
        chk("yield_data", bus.o_rf_data,      32'h88);
        drive_wb(1'b0, 5'd0, 1'b0, 32'h0);
        step();

        // Debug write to r0 is popped without a register-file write.
        drive_dbg(1'b1, 5'd0, 32'h77);
        step();
        chk("dr0_count1", 32'(bus.o_dbg_count), 32'd1);
        drive_dbg(1'b0, 5'd0, 32'h0);
        step();
        chk("dr0_count0", 32'(bus.o_dbg_count), 32'd0);
        chk("dr0_we",     32'(bus.o_rf_we),     32'd0);
        step();

        // Fill the FIFO under WB traffic, try a refused push, then reset asynchronously.
        drive_wb(1'b1, 5'd9, 1'b0, 32'h99);
        drive_dbg(1'b1, 5'd6, 32'h66);
        step();
        drive_dbg(1'b1, 5'd10, 32'hAB);
        step();
        chk("full_count", 32'(bus.o_dbg_count), 32'd2);
        chk("full_ready", 32'(bus.o_dbg_ready), 32'd0);
        drive_dbg(1'b1, 5'd11, 32'hCD);
        step();
        chk("refused_count", 32'(bus.o_dbg_count), 32'd2);
        drive_dbg(1'b0, 5'd0, 32'h0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.o_dbg_count), 32'd0);
        chk("arst_stall", 32'(bus.o_stall_wb),  32'd0);
        chk("arst_we",    32'(bus.o_rf_we),     32'd0);
        chk("arst_ready", 32'(bus.o_dbg_ready), 32'd1);
        drive_wb(1'b0, 5'd0, 1'b0, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_we", 32'(bus.o_rf_we), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
